// File: rtl/led_mode_pkg.sv
// Shared types and pattern helpers for the button-driven LED mode controller.
package led_mode_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    localparam logic [3:0] PAT_INIT_BLINK = 4'b0000;
    localparam logic [3:0] PAT_INIT_CHASE = 4'b0001;
    localparam logic [3:0] PAT_INIT_COUNT = 4'b0000;

    function automatic logic [3:0] init_pattern(input mode_t m);
        case (m)
            MODE_BLINK: return PAT_INIT_BLINK;
            MODE_CHASE: return PAT_INIT_CHASE;
            MODE_COUNT: return PAT_INIT_COUNT;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] step_pattern(input mode_t m, input logic [3:0] led);
        case (m)
            MODE_BLINK: return ~led;
            MODE_CHASE: return {led[2:0], led[3]};
            MODE_COUNT: return led + 4'd1;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic mode_t mode_fwd(input mode_t m);
        case (m)
            MODE_OFF:   return MODE_BLINK;
            MODE_BLINK: return MODE_CHASE;
            MODE_CHASE: return MODE_COUNT;
            default:    return MODE_OFF;
        endcase
    endfunction

    function automatic mode_t mode_back(input mode_t m);
        case (m)
            MODE_OFF:   return MODE_COUNT;
            MODE_BLINK: return MODE_OFF;
            MODE_CHASE: return MODE_BLINK;
            default:    return MODE_CHASE;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DEB_BITS = 18
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS
);

    logic [1:0]          sync;
    logic [DEB_BITS-1:0] cnt;
    logic                level_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync    <= '0;
            cnt     <= '0;
            LEVEL   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], BTN};
            level_q <= LEVEL;
            if (sync[1] == LEVEL) begin
                cnt <= '0;
            end else if (&cnt) begin
                LEVEL <= ~LEVEL;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DEB_BITS'(1);
            end
        end
    end

    assign PRESS = LEVEL & ~level_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED pattern controller: three debounced buttons drive a four-mode FSM stepped by a prescaler.
import led_mode_pkg::*;

module led_mode_ctrl #(
    parameter int unsigned DEB_BITS  = 18,
    parameter int unsigned TICK_BITS = 21
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_NEXT,
    input  logic       BTN_PREV,
    input  logic       BTN_PAUSE,
    output logic [3:0] LED,
    output logic [1:0] MODE,
    output logic       STEP
);

    logic [2:0] btn_raw;
    logic [2:0] btn_ev;
    logic [2:0] unused_level;

    assign btn_raw = {BTN_PAUSE, BTN_PREV, BTN_NEXT};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
            .CLK   (CLK),
            .RST_N (RST_N),
            .BTN   (btn_raw[i]),
            .LEVEL (unused_level[i]),
            .PRESS (btn_ev[i])
        );
    end

    mode_t                mode, mode_nxt;
    logic                 paused, paused_nxt;
    logic [TICK_BITS-1:0] presc, presc_nxt;
    logic [3:0]           led_nxt;
    logic                 step_nxt;
    logic                 tick;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode   <= MODE_OFF;
            paused <= 1'b0;
            presc  <= '0;
            LED    <= '0;
            STEP   <= 1'b0;
        end else begin
            mode   <= mode_nxt;
            paused <= paused_nxt;
            presc  <= presc_nxt;
            LED    <= led_nxt;
            STEP   <= step_nxt;
        end
    end

    // A mode change wins over a coincident tick: the tick is dropped, not deferred.
    always_comb begin
        mode_nxt   = mode;
        paused_nxt = paused ^ btn_ev[2];
        presc_nxt  = presc;
        led_nxt    = LED;
        step_nxt   = 1'b0;
        tick       = (&presc) & ~paused;
        if (btn_ev[0] ^ btn_ev[1]) begin
            mode_nxt  = btn_ev[0] ? mode_fwd(mode) : mode_back(mode);
            led_nxt   = init_pattern(mode_nxt);
            presc_nxt = '0;
        end else begin
            if (!paused) presc_nxt = presc + TICK_BITS'(1);
            if (tick) begin
                led_nxt  = step_pattern(mode, LED);
                step_nxt = 1'b1;
            end
        end
    end

    assign MODE = mode;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed + randomized bench for led_mode_ctrl with an event-scheduled reference model.
module tb_led_mode_ctrl;

    localparam int DEB  = 3;
    localparam int TB   = 3;
    localparam int LAT  = 2**DEB + 3;   // edges from first sampling edge to MODE update
    localparam int PER  = 2**TB;        // edges between steps

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       BTN_NEXT = 1'b0, BTN_PREV = 1'b0, BTN_PAUSE = 1'b0;
    logic [3:0] LED;
    logic [1:0] MODE;
    logic       STEP;
    bit         clk_en = 1'b0;

    led_mode_ctrl #(.DEB_BITS(DEB), .TICK_BITS(TB)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BTN_NEXT  (BTN_NEXT),
        .BTN_PREV  (BTN_PREV),
        .BTN_PAUSE (BTN_PAUSE),
        .LED       (LED),
        .MODE      (MODE),
        .STEP      (STEP)
    );

    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    int ntests = 0, nfail = 0, ecnt = 0;
    bit ev_n[int], ev_p[int], ev_z[int];
    int r_mode = 0, r_k = 0, r_cnt = 0;
    bit r_paused = 1'b0, r_step = 1'b0;

    // Pattern after k steps in mode m, from the mode's starting pattern.
    function automatic logic [3:0] pat(input int m, input int k);
        case (m)
            1:       return (k % 2 == 1) ? 4'b1111 : 4'b0000;
            2:       return 4'(1 << (k % 4));
            3:       return 4'(k % 16);
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        r_mode = 0; r_k = 0; r_cnt = 0; r_paused = 1'b0; r_step = 1'b0;
        ev_n.delete(); ev_p.delete(); ev_z.delete();
    endtask

    task automatic model_edge();
        bit n, p, z, tk;
        if (!RST_N) begin
            model_reset();
            return;
        end
        n  = ev_n.exists(ecnt);
        p  = ev_p.exists(ecnt);
        z  = ev_z.exists(ecnt);
        tk = !r_paused && (r_cnt == PER - 1);
        r_step = 1'b0;
        if (n != p) begin
            r_mode = n ? (r_mode + 1) % 4 : (r_mode + 3) % 4;
            r_k = 0;
            r_cnt = 0;
        end else begin
            if (!r_paused) r_cnt = (r_cnt + 1) % PER;
            if (tk) begin
                r_k++;
                r_step = 1'b1;
            end
        end
        if (z) r_paused = !r_paused;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %b expected %b (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    task automatic clk1();
        @(posedge CLK);
        ecnt++;
        model_edge();
        @(negedge CLK);
        chk("led", LED, pat(r_mode, r_k));
        chk("mode", {2'b00, MODE}, 4'(r_mode));
        chk("step", {3'b000, STEP}, {3'b000, r_step});
    endtask

    task automatic start(input bit n, input bit p, input bit z);
        BTN_NEXT = n; BTN_PREV = p; BTN_PAUSE = z;
        if (n) ev_n[ecnt + LAT] = 1'b1;
        if (p) ev_p[ecnt + LAT] = 1'b1;
        if (z) ev_z[ecnt + LAT] = 1'b1;
    endtask

    task automatic release_btns();
        BTN_NEXT = 1'b0; BTN_PREV = 1'b0; BTN_PAUSE = 1'b0;
    endtask

    task automatic press(input bit n, input bit p, input bit z);
        start(n, p, z);
        repeat (16) clk1();
        release_btns();
        repeat (16) clk1();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) clk1();
        RST_N = 1'b1;
    endtask

    task automatic bound_ok(input string tag, input int guard, input int limit);
        ntests++;
        assert (guard < limit) else begin
            nfail++;
            $error("FAIL %s: waited %0d cycles, limit %0d", tag, guard, limit);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int nstep;
        int exp_mode[4] = '{1, 2, 3, 0};

        // 1: async reset with no clock, then a button held across reset release
        #1 RST_N = 1'b0;
        #1;
        chk("rst_led", LED, 4'b0000);
        chk("rst_mode", {2'b00, MODE}, 4'd0);
        chk("rst_step", {3'b000, STEP}, 4'd0);
        BTN_NEXT = 1'b1;
        clk_en = 1'b1;
        repeat (3) clk1();
        RST_N = 1'b1;
        ev_n[ecnt + LAT] = 1'b1;
        repeat (LAT - 1) clk1();
        chk("held_before", {2'b00, MODE}, 4'd0);
        clk1();
        chk("held_event", {2'b00, MODE}, 4'd1);
        repeat (5) clk1();
        BTN_NEXT = 1'b0;
        repeat (30) clk1();
        chk("held_once", {2'b00, MODE}, 4'd1);

        // 2: NEXT walks the ring forward, PREV wraps backward
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0, 1'b0);
            chk("next_seq", {2'b00, MODE}, 4'(exp_mode[i]));
        end
        press(1'b0, 1'b1, 1'b0);
        chk("prev_wrap", {2'b00, MODE}, 4'd3);

        // 3: CHASE stepping cadence
        press(1'b0, 1'b1, 1'b0);
        chk("chase_mode", {2'b00, MODE}, 4'd2);
        guard = 0;
        while (!r_step && guard < 20) begin clk1(); guard++; end
        bound_ok("chase_align", guard, 20);
        nstep = 0;
        for (int i = 0; i < 5 * PER; i++) begin
            clk1();
            if (STEP) nstep++;
        end
        chk("chase_steps", 4'(nstep), 4'd5);

        // 4: bounce shorter than the debounce window
        for (int i = 0; i < 40; i++) begin
            BTN_NEXT = ((i / 3) % 2 == 0);
            clk1();
        end
        BTN_NEXT = 1'b0;
        repeat (20) clk1();
        chk("bounce", {2'b00, MODE}, 4'd2);

        // 5: pause in COUNT at 0101, hold, resume to 0110
        press(1'b1, 1'b0, 1'b0);
        chk("count_mode", {2'b00, MODE}, 4'd3);
        guard = 0;
        while (!(r_step && r_k == 4) && guard < 100) begin clk1(); guard++; end
        bound_ok("count_k4", guard, 100);
        press(1'b0, 1'b0, 1'b1);
        chk("paused_val", LED, 4'b0101);
        for (int i = 0; i < 64; i++) begin
            clk1();
            chk("pause_led", LED, 4'b0101);
            chk("pause_step", {3'b000, STEP}, 4'd0);
        end
        start(1'b0, 1'b0, 1'b1);
        guard = 0;
        while (!r_step && guard < 40) begin clk1(); guard++; end
        bound_ok("resume_wait", guard, 40);
        chk("resume", LED, 4'b0110);
        release_btns();
        repeat (20) clk1();

        // 6: simultaneous NEXT+PREV cancel; async reset mid-CHASE
        press(1'b1, 1'b1, 1'b0);
        chk("cancel", {2'b00, MODE}, 4'd3);
        press(1'b0, 1'b1, 1'b0);
        guard = 0;
        while (!(r_mode == 2 && r_k % 4 == 2) && guard < 100) begin clk1(); guard++; end
        bound_ok("chase_0100", guard, 100);
        chk("pre_rst_led", LED, 4'b0100);
        #1 RST_N = 1'b0;
        #1;
        chk("async_led", LED, 4'b0000);
        chk("async_mode", {2'b00, MODE}, 4'd0);
        model_reset();
        repeat (2) clk1();
        RST_N = 1'b1;
        repeat (4) clk1();

        // Randomized button traffic against the model
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0, 1: press(1'b1, 1'b0, 1'b0);
                2:    press(1'b0, 1'b1, 1'b0);
                3:    press(1'b0, 1'b0, 1'b1);
                4:    press(1'b1, 1'b1, 1'b0);
                default: press(1'b1, 1'b0, 1'b1);
            endcase
            repeat ($urandom_range(0, 12)) clk1();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
